// File: rtl/gsm_tile_sc_pkg.sv
// Shared types and helpers for the single-clock GSM tile: FSM encodings and a ceil-log2 helper.
package gsm_tile_sc_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gsm_state_e;

  // Ceil(log2(value)), never less than 1 so it can size a vector directly.
  function automatic int clogb(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gsm_tile_sc_rr_arb.sv
// Round-robin arbiter: one-hot grant from a request vector; priority starts just after the last winner.
module gsm_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;
  logic          found;
  int            idx;

  always_comb begin
    o_gnt  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && i_req[idx[PW-1:0]]) begin
        found               = 1'b1;
        o_gnt[idx[PW-1:0]]  = 1'b1;
        last_d              = idx[PW-1:0];
      end
    end
  end

  // Reset to the top index so that port 0 has first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= PW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/gsm_tile_sc.sv
// Shared-buffer NUM_IN x NUM_OUT cell switch with multicast refcounting and a self-loading free list.
// Optional statistics counters are built when GSM_TILE_SC_STATS_EN is defined.
module gsm_tile_sc
  import gsm_tile_sc_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int DWIDTH  = 128,
  parameter int AWIDTH  = 7,
  parameter int QAWIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         i_ingress_valid,
  output logic [NUM_IN-1:0]         o_ingress_ready,
  input  logic [NUM_IN*NUM_OUT-1:0] i_ingress_mcast,
  input  logic [NUM_IN*DWIDTH-1:0]  i_ingress_data,
  input  logic [NUM_OUT-1:0]        i_egress_rd,
  output logic [NUM_OUT-1:0]        o_egress_valid,
  output logic [NUM_OUT*DWIDTH-1:0] o_egress_data,
  output logic [AWIDTH:0]           o_free_cnt,
  output logic                      o_init_done
`ifdef GSM_TILE_SC_STATS_EN
  ,
  output logic [31:0]               o_stat_in,
  output logic [31:0]               o_stat_out,
  output logic [31:0]               o_stat_drop
`endif
);

  localparam int NCELL  = 1 << AWIDTH;
  localparam int QDEPTH = 1 << QAWIDTH;
  localparam int RCW    = clogb(NUM_OUT + 1);
  localparam int OSW    = clogb(NUM_OUT);
  localparam logic [AWIDTH:0]  FL_ONE = 1;
  localparam logic [QAWIDTH:0] Q_ONE  = 1;

  typedef logic [AWIDTH-1:0] ptr_t;

  gsm_state_e              state_q, state_d;
  logic [AWIDTH:0]         fl_wr_q, fl_wr_d, fl_rd_q, fl_rd_d;
  logic [QAWIDTH:0]        q_wr_q [NUM_OUT];
  logic [QAWIDTH:0]        q_wr_d [NUM_OUT];
  logic [QAWIDTH:0]        q_rd_q [NUM_OUT];
  logic [QAWIDTH:0]        q_rd_d [NUM_OUT];
  logic [1:0]              of_cnt_q [NUM_OUT];
  logic [1:0]              of_cnt_d [NUM_OUT];
  logic [NUM_OUT-1:0]      of_wr_q, of_wr_d, of_rd_q, of_rd_d;

  logic [DWIDTH-1:0]       cell_mem   [NCELL];
  ptr_t                    fl_mem     [NCELL];
  logic [RCW-1:0]          refcnt_mem [NCELL];
  ptr_t                    q_mem      [NUM_OUT][QDEPTH];
  logic [DWIDTH-1:0]       of_mem     [NUM_OUT][2];

  logic                    run, fl_empty, in_any, acc_alloc, eg_any, free_push;
  logic [NUM_OUT-1:0]      q_empty, q_full, eg_req, eg_gnt, sel_mc, pop;
  logic [NUM_IN-1:0]       in_req, in_gnt;
  logic [DWIDTH-1:0]       sel_data;
  logic [RCW-1:0]          sel_cnt, rc_old;
  logic [OSW-1:0]          eg_sel;
  ptr_t                    alloc_ptr, rd_ptr;

  always_comb begin
    run      = (state_q == ST_RUN);
    fl_empty = (fl_wr_q == fl_rd_q);
    q_empty  = '0;
    q_full   = '0;
    eg_req   = '0;
    pop      = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      q_empty[j] = (q_wr_q[j] == q_rd_q[j]);
      q_full[j]  = (q_wr_q[j][QAWIDTH] != q_rd_q[j][QAWIDTH]) &&
                   (q_wr_q[j][QAWIDTH-1:0] == q_rd_q[j][QAWIDTH-1:0]);
      // Output FIFO slots are reserved at grant time since the read lands one cycle later.
      eg_req[j]  = !q_empty[j] && (of_cnt_q[j] != 2'd2);
      pop[j]     = i_egress_rd[j] && (of_cnt_q[j] != 2'd0);
    end
  end

  always_comb begin
    in_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_req[i] = run && i_ingress_valid[i] && !fl_empty &&
                  ((i_ingress_mcast[i*NUM_OUT +: NUM_OUT] & q_full) == '0);
    end
  end

  gsm_rr_arb #(.N(NUM_IN))  u_in_arb (.clk(clk), .rst_n(rst_n), .i_req(in_req), .o_gnt(in_gnt));
  gsm_rr_arb #(.N(NUM_OUT)) u_eg_arb (.clk(clk), .rst_n(rst_n), .i_req(eg_req), .o_gnt(eg_gnt));

  always_comb begin
    sel_mc   = '0;
    sel_data = '0;
    sel_cnt  = '0;
    eg_sel   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_gnt[i]) begin
        sel_mc   = i_ingress_mcast[i*NUM_OUT +: NUM_OUT];
        sel_data = i_ingress_data[i*DWIDTH +: DWIDTH];
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      sel_cnt = sel_cnt + RCW'(sel_mc[j]);
      if (eg_gnt[j]) eg_sel = OSW'(j);
    end
    in_any    = |in_gnt;
    acc_alloc = in_any && (sel_mc != '0);
    alloc_ptr = fl_mem[fl_rd_q[AWIDTH-1:0]];
    eg_any    = |eg_gnt;
    rd_ptr    = q_mem[eg_sel][q_rd_q[eg_sel][QAWIDTH-1:0]];
    rc_old    = refcnt_mem[rd_ptr];
    free_push = eg_any && (rc_old == RCW'(1));
  end

  always_comb begin
    state_d  = state_q;
    fl_wr_d  = fl_wr_q;
    fl_rd_d  = fl_rd_q;
    q_wr_d   = q_wr_q;
    q_rd_d   = q_rd_q;
    of_cnt_d = of_cnt_q;
    of_wr_d  = of_wr_q;
    of_rd_d  = of_rd_q;
    if (state_q == ST_INIT) begin
      fl_wr_d = fl_wr_q + FL_ONE;
      if (&fl_wr_q[AWIDTH-1:0]) state_d = ST_RUN;
    end
    if (free_push) fl_wr_d = fl_wr_q + FL_ONE;
    if (acc_alloc) fl_rd_d = fl_rd_q + FL_ONE;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (acc_alloc && sel_mc[j]) q_wr_d[j] = q_wr_q[j] + Q_ONE;
      if (eg_gnt[j])              q_rd_d[j] = q_rd_q[j] + Q_ONE;
      if (eg_gnt[j])              of_wr_d[j] = ~of_wr_q[j];
      if (pop[j])                 of_rd_d[j] = ~of_rd_q[j];
      case ({eg_gnt[j], pop[j]})
        2'b10:   of_cnt_d[j] = of_cnt_q[j] + 2'd1;
        2'b01:   of_cnt_d[j] = of_cnt_q[j] - 2'd1;
        default: of_cnt_d[j] = of_cnt_q[j];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      fl_wr_q  <= '0;
      fl_rd_q  <= '0;
      q_wr_q   <= '{default: '0};
      q_rd_q   <= '{default: '0};
      of_cnt_q <= '{default: '0};
      of_wr_q  <= '0;
      of_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      fl_wr_q  <= fl_wr_d;
      fl_rd_q  <= fl_rd_d;
      q_wr_q   <= q_wr_d;
      q_rd_q   <= q_rd_d;
      of_cnt_q <= of_cnt_d;
      of_wr_q  <= of_wr_d;
      of_rd_q  <= of_rd_d;
    end
  end

  // Storage arrays: free list is seeded with the write index itself while initialising.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) fl_mem[fl_wr_q[AWIDTH-1:0]] <= fl_wr_q[AWIDTH-1:0];
    else if (free_push)     fl_mem[fl_wr_q[AWIDTH-1:0]] <= rd_ptr;
    if (acc_alloc) cell_mem[alloc_ptr] <= sel_data;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (acc_alloc && sel_mc[j]) q_mem[j][q_wr_q[j][QAWIDTH-1:0]] <= alloc_ptr;
    end
    if (eg_any) of_mem[eg_sel][of_wr_q[eg_sel]] <= cell_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NCELL; k++) refcnt_mem[k] <= '0;
    end else begin
      if (acc_alloc) refcnt_mem[alloc_ptr] <= sel_cnt;
      if (eg_any)    refcnt_mem[rd_ptr]    <= rc_old - RCW'(1);
    end
  end

  always_comb begin
    o_ingress_ready = in_gnt;
    o_free_cnt      = fl_wr_q - fl_rd_q;
    o_init_done     = run;
    o_egress_valid  = '0;
    o_egress_data   = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      o_egress_valid[j] = (of_cnt_q[j] != 2'd0);
      if (o_egress_valid[j]) o_egress_data[j*DWIDTH +: DWIDTH] = of_mem[j][of_rd_q[j]];
    end
  end

`ifdef GSM_TILE_SC_STATS_EN
  logic [31:0] stat_in_q, stat_in_d, stat_out_q, stat_out_d, stat_drop_q, stat_drop_d;

  always_comb begin
    stat_in_d   = stat_in_q + 32'(in_any);
    stat_drop_d = stat_drop_q + 32'(in_any && !acc_alloc);
    stat_out_d  = stat_out_q;
    for (int j = 0; j < NUM_OUT; j++) stat_out_d = stat_out_d + 32'(pop[j]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_in_q   <= '0;
      stat_out_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_in_q   <= stat_in_d;
      stat_out_q  <= stat_out_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign o_stat_in   = stat_in_q;
  assign o_stat_out  = stat_out_q;
  assign o_stat_drop = stat_drop_q;
`endif

endmodule
